// File: rtl/ysyx_22041071_mdu_pkg.sv
// Shared definitions for the MUL/DIV sequencer: ALU_ctrl opcodes, FSM states
// and the per-opcode unit-control decode.
package ysyx_22041071_mdu_pkg;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t ALU_MUL   = 5'd19;
  localparam alu_op_t ALU_MULH  = 5'd20;
  localparam alu_op_t ALU_MULHU = 5'd21;
  localparam alu_op_t ALU_MULW  = 5'd22;
  localparam alu_op_t ALU_DIV   = 5'd23;
  localparam alu_op_t ALU_DIVU  = 5'd24;
  localparam alu_op_t ALU_DIVW  = 5'd25;
  localparam alu_op_t ALU_DIVUW = 5'd26;
  localparam alu_op_t ALU_REM   = 5'd27;
  localparam alu_op_t ALU_REMU  = 5'd28;
  localparam alu_op_t ALU_REMUW = 5'd29;
  localparam alu_op_t ALU_REMW  = 5'd30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } mdu_state_e;

  typedef struct packed {
    logic       mul_sel;
    logic [1:0] mul_signed;
    logic       mulw;
    logic       div_signed;
    logic       divw;
  } mdu_ctrl_t;

  function automatic logic is_mdu_op(input alu_op_t op);
    return (op >= ALU_MUL) && (op <= ALU_REMW);
  endfunction

  function automatic logic is_mul_op(input alu_op_t op);
    return (op >= ALU_MUL) && (op <= ALU_MULW);
  endfunction

  function automatic mdu_ctrl_t decode_ctrl(input alu_op_t op);
    mdu_ctrl_t c;
    c = '0;
    c.mul_sel = is_mul_op(op);
    case (op)
      ALU_MULH:                               c.mul_signed = 2'b11;
      ALU_MULW:                               begin c.mul_signed = 2'b11; c.mulw = 1'b1; end
      ALU_DIV, ALU_REM:                       c.div_signed = 1'b1;
      ALU_DIVW, ALU_REMW:                     begin c.div_signed = 1'b1; c.divw = 1'b1; end
      ALU_DIVUW, ALU_REMUW:                   c.divw = 1'b1;
      default:                                ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ysyx_22041071_mdu_ctrl.sv
// EX-stage sequencer for the shared multiplier/divider: accepts one op, runs the
// unit handshake, formats and buffers the result, and handles flush/timeout.
module ysyx_22041071_mdu_ctrl
  import ysyx_22041071_mdu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 127,
  parameter int CNT_W   = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [4:0]      op_code,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic            res_err,
  output logic            busy,
  output logic [XLEN-1:0] opa,
  output logic [XLEN-1:0] opb,
  output logic            mul_valid,
  output logic            mulw,
  output logic [1:0]      mul_signed,
  input  logic            mul_ready,
  input  logic            mul_out_valid,
  input  logic [XLEN-1:0] result_h,
  input  logic [XLEN-1:0] result_l,
  output logic            div_valid,
  output logic            div_signed,
  output logic            divw,
  input  logic            div_ready,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] rema,
  output logic            unit_flush
);

  mdu_state_e       state_q, state_d;
  alu_op_t          op_q;
  logic [CNT_W-1:0] cnt_q;
  mdu_ctrl_t        ctrl;
  logic             launch;
  logic             capture;
  logic             abort;
  logic             unit_done;
  logic             timed_out;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] format_result(
    input alu_op_t         op,
    input logic [XLEN-1:0] rh,
    input logic [XLEN-1:0] rl,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r
  );
    case (op)
      ALU_MUL:               return rl;
      ALU_MULH, ALU_MULHU:   return rh;
      ALU_MULW:              return sext32(rl);
      ALU_DIV, ALU_DIVU:     return q;
      ALU_DIVW, ALU_DIVUW:   return sext32(q);
      ALU_REM, ALU_REMU:     return r;
      ALU_REMUW, ALU_REMW:   return sext32(r);
      default:               return '0;
    endcase
  endfunction

  assign ctrl      = decode_ctrl(op_q);
  assign unit_done = ctrl.mul_sel ? mul_out_valid : div_out_valid;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_DONE);

  // NOTE: every output of this block gets a default before the case; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    op_ready   = 1'b0;
    mul_valid  = 1'b0;
    mulw       = 1'b0;
    mul_signed = 2'b00;
    div_valid  = 1'b0;
    div_signed = 1'b0;
    divw       = 1'b0;
    unit_flush = 1'b0;
    launch     = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Gated by reset so op_ready is also low while reset is held.
        op_ready = reset & ~flush;
        if (op_valid && op_ready && is_mdu_op(op_code)) begin
          launch  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          unit_flush = 1'b1;
          state_d    = ST_IDLE;
        end else if (ctrl.mul_sel) begin
          mul_valid  = 1'b1;
          mul_signed = ctrl.mul_signed;
          mulw       = ctrl.mulw;
          if (mul_ready) state_d = ST_WAIT;
        end else begin
          div_valid  = 1'b1;
          div_signed = ctrl.div_signed;
          divw       = ctrl.divw;
          if (div_ready) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          unit_flush = 1'b1;
          state_d    = ST_IDLE;
        end else if (unit_done) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else if (timed_out) begin
          unit_flush = 1'b1;
          abort      = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush || res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      opa      <= '0;
      opb      <= '0;
      cnt_q    <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (launch) begin
        op_q <= op_code;
        opa  <= src_a;
        opb  <= src_b;
      end

      // Held at zero through ISSUE so WAIT always starts counting from zero.
      if (state_q == ST_ISSUE)     cnt_q <= '0;
      else if (state_q == ST_WAIT) cnt_q <= cnt_q + CNT_W'(1);

      if (capture) begin
        res_data <= format_result(op_q, result_h, result_l, quot, rema);
        res_err  <= 1'b0;
      end else if (abort) begin
        res_data <= '0;
        res_err  <= 1'b1;
      end else if (state_d == ST_IDLE) begin
        res_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_mdu_ctrl.sv
// Self-checking bench for ysyx_22041071_mdu_ctrl: directed scenarios plus
// randomized operations against a result/flag model derived from the op table.
module tb_ysyx_22041071_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [4:0]  op_code;
  logic [63:0] src_a, src_b;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        res_err;
  logic        busy;
  logic [63:0] opa, opb;
  logic        mul_valid, mulw;
  logic [1:0]  mul_signed;
  logic        mul_ready, mul_out_valid;
  logic [63:0] result_h, result_l;
  logic        div_valid, div_signed, divw;
  logic        div_ready, div_out_valid;
  logic [63:0] quot, rema;
  logic        unit_flush;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22041071_mdu_ctrl dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy), .opa(opa), .opb(opb),
    .mul_valid(mul_valid), .mulw(mulw), .mul_signed(mul_signed),
    .mul_ready(mul_ready), .mul_out_valid(mul_out_valid),
    .result_h(result_h), .result_l(result_l),
    .div_valid(div_valid), .div_signed(div_signed), .divw(divw),
    .div_ready(div_ready), .div_out_valid(div_out_valid),
    .quot(quot), .rema(rema), .unit_flush(unit_flush)
  );

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Result the EX stage should see, straight from the opcode table.
  function automatic logic [63:0] ref_result(input logic [4:0] op, input logic [63:0] rh,
                                             input logic [63:0] rl, input logic [63:0] q,
                                             input logic [63:0] r);
    logic [63:0] pick;
    if (op == 5'd19)      pick = rl;
    else if (op <= 5'd21) pick = rh;
    else if (op == 5'd22) pick = rl;
    else if (op <= 5'd26) pick = q;
    else                  pick = r;
    if (op inside {5'd22, 5'd25, 5'd26, 5'd29, 5'd30})
      pick = {{32{pick[31]}}, pick[31:0]};
    return pick;
  endfunction

  function automatic logic [1:0] ref_mul_signed(input logic [4:0] op);
    return (op == 5'd20 || op == 5'd22) ? 2'b11 : 2'b00;
  endfunction

  task automatic idle_inputs();
    op_valid = 0; op_code = 0; src_a = 0; src_b = 0; flush = 0; res_ready = 0;
    mul_ready = 0; mul_out_valid = 0; result_h = 0; result_l = 0;
    div_ready = 0; div_out_valid = 0; quot = 0; rema = 0;
  endtask

  // Full operation with configurable stalls; all checks inline.
  task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int rdy_dly, input int ov_dly, input int rr_dly,
                        input logic [63:0] rh, input logic [63:0] rl,
                        input logic [63:0] q, input logic [63:0] r, input bit stale);
    logic [63:0] exp_data;
    bit          is_mul;
    int          held;
    exp_data = ref_result(op, rh, rl, q, r);
    is_mul   = (op <= 5'd22);

    @(negedge clk);
    op_valid = 1; op_code = op; src_a = a; src_b = b;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      failures++; $display("FAIL accept_ready op=%0d got=%b want=1", op, op_ready);
    end
    @(negedge clk);
    op_valid = 0; op_code = 5'd0; src_a = rnd64(); src_b = ~b;
    #1;
    checks++;
    if (opa !== a || opb !== b) begin
      failures++; $display("FAIL latched_operands op=%0d got=%h/%h want=%h/%h", op, opa, opb, a, b);
    end
    checks++;
    if (busy !== 1'b1 || op_ready !== 1'b0) begin
      failures++; $display("FAIL issue_busy op=%0d got busy=%b op_ready=%b want 1/0", op, busy, op_ready);
    end
    checks++;
    if (is_mul) begin
      if (mul_valid !== 1'b1 || div_valid !== 1'b0 || mul_signed !== ref_mul_signed(op) ||
          mulw !== (op == 5'd22)) begin
        failures++;
        $display("FAIL mul_flags op=%0d got v=%b dv=%b s=%b w=%b want v=1 dv=0 s=%b w=%b",
                 op, mul_valid, div_valid, mul_signed, mulw, ref_mul_signed(op), op == 5'd22);
      end
    end else begin
      if (div_valid !== 1'b1 || mul_valid !== 1'b0 ||
          div_signed !== (op inside {5'd23, 5'd25, 5'd27, 5'd30}) ||
          divw !== (op inside {5'd25, 5'd26, 5'd29, 5'd30})) begin
        failures++;
        $display("FAIL div_flags op=%0d got v=%b mv=%b s=%b w=%b", op, div_valid, mul_valid,
                 div_signed, divw);
      end
    end

    held = 0;
    for (int i = 0; i <= rdy_dly; i++) begin
      if (i == rdy_dly) begin
        if (is_mul) mul_ready = 1; else div_ready = 1;
      end
      if (stale && i == 0) begin
        result_h = rnd64(); result_l = rnd64(); quot = rnd64(); rema = rnd64();
        mul_out_valid = 1; div_out_valid = 1;
      end
      #1;
      if ((is_mul ? mul_valid : div_valid) === 1'b1) held++;
      @(negedge clk);
      mul_ready = 0; div_ready = 0; mul_out_valid = 0; div_out_valid = 0;
    end
    checks++;
    if (held != rdy_dly + 1) begin
      failures++; $display("FAIL valid_hold op=%0d got=%0d want=%0d", op, held, rdy_dly + 1);
    end

    for (int i = 0; i < ov_dly; i++) begin
      if (stale) begin
        result_h = rnd64(); result_l = rnd64(); quot = rnd64(); rema = rnd64();
        if (is_mul) div_out_valid = 1; else mul_out_valid = 1;
      end
      #1;
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL wait_state op=%0d got res_valid=%b busy=%b want 0/1", op, res_valid, busy);
      end
      @(negedge clk);
      mul_out_valid = 0; div_out_valid = 0;
    end

    result_h = rh; result_l = rl; quot = q; rema = r;
    if (is_mul) mul_out_valid = 1; else div_out_valid = 1;
    @(negedge clk);
    mul_out_valid = 0; div_out_valid = 0;
    result_h = rnd64(); result_l = rnd64(); quot = rnd64(); rema = rnd64();
    #1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp_data || res_err !== 1'b0) begin
      failures++;
      $display("FAIL result op=%0d got v=%b d=%h e=%b want v=1 d=%h e=0", op, res_valid, res_data,
               res_err, exp_data);
    end

    for (int i = 0; i < rr_dly; i++) begin
      op_valid = 1; op_code = 5'd19;
      #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp_data || op_ready !== 1'b0) begin
        failures++;
        $display("FAIL done_hold op=%0d cyc=%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0", op, i,
                 res_valid, res_data, op_ready, exp_data);
      end
      @(negedge clk);
    end
    op_valid = 0; op_code = 0;
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL drain op=%0d got v=%b busy=%b want 0/0", op, res_valid, busy);
    end
  endtask

  // Accept an op and complete the unit handshake immediately; returns in WAIT.
  task automatic start_to_wait(input logic [4:0] op);
    @(negedge clk);
    op_valid = 1; op_code = op; src_a = rnd64(); src_b = rnd64();
    @(negedge clk);
    op_valid = 0; mul_ready = 1; div_ready = 1;
    @(negedge clk);
    mul_ready = 0; div_ready = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    op_valid = 1; op_code = 5'd19; src_a = rnd64(); src_b = rnd64();
    mul_ready = 1; div_ready = 1; mul_out_valid = 1; div_out_valid = 1; res_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({op_ready, res_valid, res_err, busy, mul_valid, mulw, mul_signed, div_valid, div_signed,
         divw, unit_flush} !== 12'b0 || opa !== 64'd0 || opb !== 64'd0 || res_data !== 64'd0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b v=%b busy=%b mv=%b dv=%b uf=%b opa=%h d=%h want all 0",
               op_ready, res_valid, busy, mul_valid, div_valid, unit_flush, opa, res_data);
    end
    idle_inputs();
    @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if (op_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle got rdy=%b busy=%b want 1/0", op_ready, busy);
    end
  endtask

  task automatic test_mul_basic();
    run_op(5'd19, 64'd3, 64'd5, 0, 0, 0, 64'd0, 64'd15, rnd64(), rnd64(), 1'b0);
  endtask

  task automatic test_div_stall();
    run_op(5'd25, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3, 0, 0, rnd64(), rnd64(),
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
  endtask

  task automatic test_mulw_sext();
    run_op(5'd22, rnd64(), rnd64(), 0, 1, 0, rnd64(), 64'h0000_0000_8000_0000,
           rnd64(), rnd64(), 1'b0);
  endtask

  task automatic test_flush();
    // Flush in WAIT racing the divider's completion.
    start_to_wait(5'd23);
    flush = 1; div_out_valid = 1; quot = rnd64();
    #1;
    checks++;
    if (unit_flush !== 1'b1 || op_ready !== 1'b0) begin
      failures++; $display("FAIL flush_wait_pulse got uf=%b rdy=%b want 1/0", unit_flush, op_ready);
    end
    @(negedge clk);
    flush = 0; div_out_valid = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || unit_flush !== 1'b0) begin
      failures++; $display("FAIL flush_wait_after got busy=%b v=%b uf=%b want 0/0/0", busy, res_valid, unit_flush);
    end
    div_out_valid = 1;
    @(negedge clk);
    div_out_valid = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      failures++; $display("FAIL stale_idle got busy=%b v=%b want 0/0", busy, res_valid);
    end

    // Flush in ISSUE: valid withdrawn, units cancelled.
    @(negedge clk);
    op_valid = 1; op_code = 5'd20; src_a = rnd64(); src_b = rnd64();
    @(negedge clk);
    op_valid = 0; flush = 1; mul_ready = 1;
    #1;
    checks++;
    if (mul_valid !== 1'b0 || unit_flush !== 1'b1) begin
      failures++; $display("FAIL flush_issue got mv=%b uf=%b want 0/1", mul_valid, unit_flush);
    end
    @(negedge clk);
    flush = 0; mul_ready = 0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL flush_issue_idle got busy=%b want 0", busy);
    end

    // Flush in DONE: result dropped, no unit cancel.
    start_to_wait(5'd27);
    rema = rnd64(); div_out_valid = 1;
    @(negedge clk);
    div_out_valid = 0; flush = 1; res_ready = 1;
    #1;
    checks++;
    if (unit_flush !== 1'b0 || op_ready !== 1'b0 || res_valid !== 1'b1) begin
      failures++; $display("FAIL flush_done got uf=%b rdy=%b v=%b want 0/0/1", unit_flush, op_ready, res_valid);
    end
    @(negedge clk);
    flush = 0; res_ready = 0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL flush_done_after got v=%b e=%b busy=%b want 0/0/0", res_valid, res_err, busy);
    end

    // Flush in IDLE blocks acceptance.
    flush = 1; op_valid = 1; op_code = 5'd24;
    #1;
    checks++;
    if (op_ready !== 1'b0) begin
      failures++; $display("FAIL flush_idle_ready got=%b want 0", op_ready);
    end
    @(negedge clk);
    flush = 0; op_valid = 0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL flush_idle_accept got busy=%b want 0", busy);
    end
  endtask

  task automatic test_timeout();
    int cyc, pulses;
    start_to_wait(5'd24);
    cyc = 0; pulses = 0;
    while (cyc < 300) begin
      if (res_valid === 1'b1) break;
      if (unit_flush === 1'b1) pulses++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc != 127) begin
      failures++; $display("FAIL timeout_cycles got=%0d want=127", cyc);
    end
    checks++;
    if (pulses != 1 || unit_flush !== 1'b0) begin
      failures++; $display("FAIL timeout_flush_pulses got=%0d now=%b want 1/0", pulses, unit_flush);
    end
    checks++;
    if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 64'd0) begin
      failures++; $display("FAIL timeout_result got v=%b e=%b d=%h want 1/1/0", res_valid, res_err, res_data);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL timeout_drain got v=%b e=%b busy=%b want 0/0/0", res_valid, res_err, busy);
    end
  endtask

  task automatic test_done_hold_and_drop();
    run_op(5'd28, rnd64(), rnd64(), 1, 2, 5, rnd64(), rnd64(), rnd64(), rnd64(), 1'b0);
    foreach (src_a[i]) ;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      op_valid = 1; op_code = (k == 0) ? 5'd8 : (k == 1) ? 5'd31 : 5'd18;
      #1;
      checks++;
      if (op_ready !== 1'b1) begin
        failures++; $display("FAIL drop_ready code=%0d got=%b want 1", op_code, op_ready);
      end
      @(negedge clk);
      op_valid = 0;
      #1;
      checks++;
      if (busy !== 1'b0 || mul_valid !== 1'b0 || div_valid !== 1'b0) begin
        failures++; $display("FAIL drop_code code=%0d got busy=%b mv=%b dv=%b want 0", op_code, busy,
                             mul_valid, div_valid);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    start_to_wait(5'd21);
    #1 reset = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || opa !== 64'd0 || unit_flush !== 1'b0) begin
      failures++; $display("FAIL reset_mid got busy=%b v=%b opa=%h uf=%b want 0", busy, res_valid, opa, unit_flush);
    end
    @(negedge clk);
    reset = 1; mul_out_valid = 1;
    @(negedge clk);
    mul_out_valid = 0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid_after got v=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [4:0] op;
      op = 5'($urandom_range(30, 19));
      run_op(op, rnd64(), rnd64(), $urandom_range(3, 0), $urandom_range(4, 0),
             $urandom_range(2, 0), rnd64(), rnd64(), rnd64(), rnd64(), 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div_stall();
    test_mulw_sext();
    test_flush();
    test_timeout();
    test_done_hold_and_drop();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
